sha256_seq: RTL and testbench
=============================

Name: sha256_seq

Overview:
- Command sequencer directly upstream of the W-window/compressor stage.
- Drives that stage's 8-bit CMD bus and follows its RDY handshake to hash an N-block message (1..MAX_BLK).
- Per block, it issues LOAD_H, then HASH, then SUM_STORE_H, or CALC_RES for the last block.
- Selects the message block buffer, steers H-memory writes, and reports DONE/ERR to the top level.

Parameters:
- MAX_BLK, 8, maximum blocks per message; NBLK is saturated to this.
- TMO_CYC, 1024, cycles to wait for any single RDY edge before declaring timeout.
- TMO_W, 11, timeout counter width; must satisfy 2^TMO_W > TMO_CYC.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a message when idle; ignored while BUSY.
- NBLK  in  4  number of blocks, sampled on START; 0 is treated as 1; values above MAX_BLK are saturated to MAX_BLK.
- CMD  out  8  command to the compressor: 0 IDLE, 10 LOAD_H, 20 HASH, 30 SUM_STORE_H, 40 SUM_STORE_M, 50 CALC_RES.
- RDY  in  1  compressor ready; rises on command completion, falls after CMD returns to IDLE.
- BLK  out  4  index of the message block buffer the compressor reads.
- H_INIT  out  1  selects the IV ROM (1) or the H RAM (0) onto the compressor's HD_IN.
- H_WE  out  1  H RAM write enable, qualifying HD_OUT during SUM_STORE_H.
- BUSY  out  1  high from START acceptance until DONE or ERR.
- DONE  out  1  one-cycle pulse when CALC_RES completes; RES is then valid.
- ERR  out  1  sticky timeout flag; cleared by RST or the next accepted START.

Behaviour:
- Reset values: CMD=0, BLK=0, H_INIT=1, H_WE=0, BUSY=0, DONE=0, ERR=0, FSM=S_IDLE, timeout counter=0.
- FSM states: S_IDLE, S_ISSUE, S_WAIT_HI, S_RELEASE, S_WAIT_LO, S_NEXT, S_FIN.
- S_IDLE:
  - START=1 latches NBLK (nblk_q), sets BLK=0, H_INIT=1, BUSY=1, ERR=0, op=LOAD_H.
  - Goes to S_ISSUE next cycle.
- S_ISSUE: drive CMD=op, clear the timeout counter, go to S_WAIT_HI.
- S_WAIT_HI:
  - Hold CMD=op. H_WE=1 only while op=SUM_STORE_H.
  - On RDY=1: go to S_RELEASE.
  - Otherwise increment the counter; reaching TMO_CYC is a timeout.
- S_RELEASE: CMD=0, H_WE=0, clear the counter, go to S_WAIT_LO.
- S_WAIT_LO:
  - Wait for RDY=0, with the same timeout rule.
  - Never issue a new non-IDLE CMD while RDY=1; the compressor only reacts to CMD changes.
- S_NEXT selects the next op:
  - After LOAD_H: op=HASH.
  - After HASH: op=CALC_RES if BLK==nblk_q-1, else op=SUM_STORE_H.
  - After SUM_STORE_H: BLK=BLK+1, H_INIT=0, op=LOAD_H.
  - After CALC_RES: go to S_FIN.
  - All other cases: go to S_ISSUE.
- S_FIN: DONE=1 for one cycle, BUSY=0, go to S_IDLE; CMD is already 0.
- Command latency:
  - Each command costs 2 issue cycles plus the compressor's busy time plus 2 release cycles.
  - Minimum gap between consecutive non-IDLE CMD values is 3 cycles.
- Timeout: CMD=0, H_WE=0, ERR=1, BUSY=0, no DONE, return to S_IDLE.
- Boundaries:
  - RDY already high on entry to S_ISSUE: still pass through S_WAIT_HI, accept RDY immediately, then release.
  - START asserted while BUSY: ignored, no state change.
  - RST mid-operation: all outputs return to reset values next cycle. The compressor sees CMD=0 and returns to idle.
  - The BLK increment cannot wrap: nblk_q ≤ MAX_BLK ≤ 15.
  - RDY glitch high for one cycle during S_WAIT_LO: ignored, only its level is sampled in S_WAIT_HI/S_WAIT_LO.
  - SUM_STORE_M (40) is never issued by this block. The code exists only in the shared package.

Decomposition:
- Shared package sha256_pkg holds:
  - CMD code constants (IDLE/LOAD_H/HASH/SUM_STORE_H/SUM_STORE_M/CALC_RES); the compressor uses the same ones.
  - FSM state encoding.
  - The IV ROM contents.
- One natural sub-module, sha256_seq_tmo:
  - Loadable timeout counter with clear, enable and expiry flag, parameterised by TMO_CYC/TMO_W.

Test Plan:
1. Single block:
   - Stimulus: NBLK=1, START; model compressor raises RDY 64 cycles after CMD=20 and 9 cycles after the others.
   - Required: CMD sequence 10,0,20,0,50,0; BLK=0 throughout; H_INIT=1; H_WE never set; one DONE pulse; BUSY falls with DONE.
2. Two blocks:
   - Stimulus: NBLK=2, START.
   - Required: CMD sequence 10,20,30,10,20,50 with IDLE gaps.
   - H_WE high only during CMD=30.
   - BLK goes 0→1 after the SUM_STORE_H release; H_INIT=0 from the second LOAD_H onward.
3. Saturation:
   - Stimulus: NBLK=0, then NBLK=15 with MAX_BLK=8.
   - Required: NBLK=0 behaves exactly as 1 block; NBLK=15 gives 8 LOAD_H commands, BLK ends at 7, one CALC_RES.
4. Timeout:
   - Stimulus: compressor never raises RDY after CMD=20.
   - Required: exactly TMO_CYC cycles after entering S_WAIT_HI, CMD=0, ERR=1, BUSY=0, no DONE; next START clears ERR.
5. Protocol:
   - Stimulus: RDY held high 5 extra cycles after CMD→0; START pulsed while BUSY.
   - Required: the next command is delayed until RDY falls; the extra START has no effect and the CMD stream is unchanged.
6. Reset mid-HASH:
   - Stimulus: assert RST while CMD=20 in a 2-block run.
   - Required: next cycle CMD=0, BLK=0, H_INIT=1, BUSY=0, ERR=0; a fresh START then completes normally.

Source files
------------

// File: rtl/sha256_pkg.sv
// Definitions shared by the SHA-256 sequencer and the compressor it drives:
// command codes, sequencer state encoding and the initial hash value ROM.
package sha256_pkg;

    typedef logic [7:0] cmd_t;

    localparam cmd_t CMD_IDLE        = 8'd0;
    localparam cmd_t CMD_LOAD_H      = 8'd10;
    localparam cmd_t CMD_HASH        = 8'd20;
    localparam cmd_t CMD_SUM_STORE_H = 8'd30;
    localparam cmd_t CMD_SUM_STORE_M = 8'd40;
    localparam cmd_t CMD_CALC_RES    = 8'd50;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    // Initial hash words H0..H7, served by the IV ROM when H_INIT is high.
    function automatic logic [31:0] iv_word(input logic [2:0] idx);
        case (idx)
            3'd0:    iv_word = 32'h6a09e667;
            3'd1:    iv_word = 32'hbb67ae85;
            3'd2:    iv_word = 32'h3c6ef372;
            3'd3:    iv_word = 32'ha54ff53a;
            3'd4:    iv_word = 32'h510e527f;
            3'd5:    iv_word = 32'h9b05688c;
            3'd6:    iv_word = 32'h1f83d9ab;
            default: iv_word = 32'h5be0cd19;
        endcase
    endfunction

    function automatic logic [3:0] sat_nblk(input logic [3:0] n, input logic [3:0] max_blk);
        if (n == 4'd0)
            sat_nblk = 4'd1;
        else if (n > max_blk)
            sat_nblk = max_blk;
        else
            sat_nblk = n;
    endfunction

endpackage

// File: rtl/sha256_seq_tmo.sv
// Handshake watchdog: counts cycles spent waiting on one RDY edge and flags
// the cycle in which the wait reaches TMO_CYC.
module sha256_seq_tmo #(
    parameter int TMO_CYC = 1024,
    parameter int TMO_W   = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fires on the TMO_CYC-th counted wait cycle, so the timeout lands exactly
    // TMO_CYC cycles after the wait began.
    assign expired_o = en_i && (cnt_q == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/sha256_seq.sv
// Command sequencer feeding the W-window/compressor: walks each message block
// through LOAD_H, HASH and SUM_STORE_H (or CALC_RES on the last block).
module sha256_seq
    import sha256_pkg::*;
#(
    parameter int MAX_BLK = 8,
    parameter int TMO_CYC = 1024,
    parameter int TMO_W   = 11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] nblk_i,
    output logic [7:0] cmd_o,
    input  logic       rdy_i,
    output logic [3:0] blk_o,
    output logic       h_init_o,
    output logic       h_we_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    logic [2:0] state_q, state_d;
    cmd_t       op_q, op_d;
    cmd_t       cmd_q, cmd_d;
    logic [3:0] nblk_q, nblk_d;
    logic [3:0] blk_q, blk_d;
    logic       h_init_q, h_init_d;
    logic       h_we_q, h_we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       tmo_clr, tmo_en, tmo_exp, timeout;

    sha256_seq_tmo #(
        .TMO_CYC(TMO_CYC),
        .TMO_W  (TMO_W)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_exp)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cmd_d    = cmd_q;
        nblk_d   = nblk_q;
        blk_d    = blk_q;
        h_init_d = h_init_q;
        h_we_d   = h_we_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tmo_clr  = 1'b0;
        tmo_en   = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nblk_d   = sat_nblk(nblk_i, 4'(MAX_BLK));
                    blk_d    = 4'd0;
                    h_init_d = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    op_d     = CMD_LOAD_H;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_d   = op_q;
                h_we_d  = (op_q == CMD_SUM_STORE_H);
                tmo_clr = 1'b1;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (rdy_i) begin
                    state_d = S_RELEASE;
                end else begin
                    tmo_en  = 1'b1;
                    timeout = tmo_exp;
                end
            end
            S_RELEASE: begin
                cmd_d   = CMD_IDLE;
                h_we_d  = 1'b0;
                tmo_clr = 1'b1;
                state_d = S_WAIT_LO;
            end
            // The compressor only acts on CMD changes, so RDY must drop before
            // the next command may be presented.
            S_WAIT_LO: begin
                if (!rdy_i) begin
                    state_d = S_NEXT;
                end else begin
                    tmo_en  = 1'b1;
                    timeout = tmo_exp;
                end
            end
            S_NEXT: begin
                state_d = S_ISSUE;
                case (op_q)
                    CMD_LOAD_H: op_d = CMD_HASH;
                    CMD_HASH:   op_d = (blk_q == nblk_q - 4'd1) ? CMD_CALC_RES : CMD_SUM_STORE_H;
                    CMD_SUM_STORE_H: begin
                        blk_d    = blk_q + 4'd1;
                        h_init_d = 1'b0;
                        op_d     = CMD_LOAD_H;
                    end
                    CMD_CALC_RES: state_d = S_FIN;
                    default:      state_d = S_ISSUE;
                endcase
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            cmd_d   = CMD_IDLE;
            h_we_d  = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= CMD_IDLE;
            cmd_q    <= CMD_IDLE;
            nblk_q   <= 4'd1;
            blk_q    <= 4'd0;
            h_init_q <= 1'b1;
            h_we_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cmd_q    <= cmd_d;
            nblk_q   <= nblk_d;
            blk_q    <= blk_d;
            h_init_q <= h_init_d;
            h_we_q   <= h_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_o    = cmd_q;
    assign blk_o    = blk_q;
    assign h_init_o = h_init_q;
    assign h_we_o   = h_we_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sha256_seq.sv
// Bench for sha256_seq: a behavioural compressor answers the handshake while the
// observed command stream is compared against the per-block command recipe.
module tb_sha256_seq;

    localparam int MAX_BLK = 8;
    localparam int TMO_CYC = 1024;
    localparam int TMO_W   = 11;

    localparam logic [7:0] C_LOAD_H   = 8'd10;
    localparam logic [7:0] C_HASH     = 8'd20;
    localparam logic [7:0] C_SUM_ST_H = 8'd30;
    localparam logic [7:0] C_CALC_RES = 8'd50;

    typedef struct {
        logic [7:0] cmd;
        logic [3:0] blk;
        logic       hInit;
        logic       hWe;
    } cmdRec_t;

    logic       clk = 1'b0;
    logic       rst, start, rdy, hInit, hWe, busy, done, err;
    logic [3:0] nblk, blk;
    logic [7:0] cmd;

    int vectors = 0;
    int miscompares = 0;

    // Compressor model settings and monitor results, shared with the main flow.
    int hashLat, otherLat, holdExtra;
    bit hangHash;
    cmdRec_t obsQ[$];
    int cycle = 0;
    int doneCnt, weViol, issueWhileRdy, minGap, busyFallViol, doneBusyViol;
    int lastIssueCycle, errCycle;
    logic [7:0] cmdAtErr;
    logic busyAtErr;

    sha256_seq #(
        .MAX_BLK(MAX_BLK),
        .TMO_CYC(TMO_CYC),
        .TMO_W  (TMO_W)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .nblk_i  (nblk),
        .cmd_o   (cmd),
        .rdy_i   (rdy),
        .blk_o   (blk),
        .h_init_o(hInit),
        .h_we_o  (hWe),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor first (sees what the DUT saw), then the compressor reacts.
    initial begin : monitorAndCompressor
        logic [7:0] prevCmd;
        logic prevBusy, prevErr;
        int lat, hold, idleRun;
        rdy = 1'b0;
        prevCmd = 8'd0; prevBusy = 1'b0; prevErr = 1'b0;
        lat = 0; hold = 0; idleRun = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (cmd != 8'd0 && prevCmd == 8'd0) begin
                obsQ.push_back('{cmd, blk, hInit, hWe});
                lastIssueCycle = cycle;
                if (rdy) issueWhileRdy++;
                if (obsQ.size() > 1 && idleRun < minGap) minGap = idleRun;
            end
            if (cmd == 8'd0) idleRun++; else idleRun = 0;
            if (hWe != (cmd == C_SUM_ST_H)) weViol++;
            if (done) begin
                doneCnt++;
                if (busy) doneBusyViol++;
            end
            if (prevBusy && !busy && !done && !err) busyFallViol++;
            if (err && !prevErr) begin
                errCycle  = cycle;
                cmdAtErr  = cmd;
                busyAtErr = busy;
            end
            prevBusy = busy;
            prevErr  = err;

            if (rst) begin
                rdy = 1'b0; lat = 0; hold = 0;
            end else if (cmd != 8'd0) begin
                if (prevCmd == 8'd0) lat = (cmd == C_HASH) ? hashLat : otherLat;
                if (!(hangHash && cmd == C_HASH)) begin
                    if (lat > 0) lat--;
                    if (lat == 0) rdy = 1'b1;
                end
            end else if (rdy) begin
                if (hold >= holdExtra) begin
                    rdy = 1'b0;
                    hold = 0;
                end else begin
                    hold++;
                end
            end
            prevCmd = cmd;
        end
    end

    task automatic applyStimulus(input logic [3:0] n, input int hLat, input int oLat, input int holdX, input bit hang);
        hashLat = hLat; otherLat = oLat; holdExtra = holdX; hangHash = hang;
        obsQ.delete();
        doneCnt = 0; weViol = 0; issueWhileRdy = 0; minGap = 1000;
        busyFallViol = 0; doneBusyViol = 0; errCycle = -1; lastIssueCycle = -1;
        nblk  = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        nblk  = 4'($urandom);
    endtask

    task automatic waitIdle(input bit extraStart);
        int cyc;
        cyc = 0;
        while (busy && cyc < 20000) begin
            start = extraStart && (cyc == 40);
            if (start) nblk = 4'd15;
            tick();
            cyc++;
        end
        start = 1'b0;
        checkOutput("idleReached", busy, 0);
        tick();
    endtask

    // Reference recipe: each block is LOAD_H, HASH, then SUM_STORE_H, except the
    // final block which ends with CALC_RES; the IV is used only for block 0.
    task automatic checkMessage(input int n, input bit hang);
        cmdRec_t expQ[$];
        int nEff, m;
        nEff = (n == 0) ? 1 : ((n > MAX_BLK) ? MAX_BLK : n);
        for (int b = 0; b < nEff; b++) begin
            expQ.push_back('{C_LOAD_H, 4'(b), (b == 0), 1'b0});
            expQ.push_back('{C_HASH, 4'(b), (b == 0), 1'b0});
            if (hang) break;
            if (b == nEff - 1) expQ.push_back('{C_CALC_RES, 4'(b), (b == 0), 1'b0});
            else               expQ.push_back('{C_SUM_ST_H, 4'(b), (b == 0), 1'b1});
        end
        checkOutput("numCmds", obsQ.size(), expQ.size());
        m = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < m; i++) begin
            checkOutput($sformatf("cmd[%0d]", i), obsQ[i].cmd, expQ[i].cmd);
            checkOutput($sformatf("blk[%0d]", i), obsQ[i].blk, expQ[i].blk);
            checkOutput($sformatf("hInit[%0d]", i), obsQ[i].hInit, expQ[i].hInit);
            checkOutput($sformatf("hWe[%0d]", i), obsQ[i].hWe, expQ[i].hWe);
        end
        checkOutput("doneCount", doneCnt, hang ? 0 : 1);
        checkOutput("errFlag", err, hang ? 1 : 0);
        checkOutput("cmdIdleAtEnd", cmd, 0);
        checkOutput("hWeOnlyDuringSumStore", weViol, 0);
        checkOutput("issueWhileRdyHigh", issueWhileRdy, 0);
        checkOutput("busyFallWithoutDone", busyFallViol, 0);
        checkOutput("doneWhileBusy", doneBusyViol, 0);
        if (obsQ.size() > 1) checkOutput("minIdleGapAtLeast3", (minGap >= 3), 1);
    endtask

    initial begin : mainFlow
        int n;
        rst = 1'b1; start = 1'b0; nblk = 4'd0;
        hashLat = 64; otherLat = 9; holdExtra = 0; hangHash = 1'b0;
        repeat (3) tick();
        checkOutput("rstCmd", cmd, 0);
        checkOutput("rstBlk", blk, 0);
        checkOutput("rstHInit", hInit, 1);
        checkOutput("rstHWe", hWe, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", err, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single block");
        applyStimulus(4'd1, 64, 9, 0, 1'b0);
        checkOutput("busyAfterStart", busy, 1);
        waitIdle(1'b0);
        checkMessage(1, 1'b0);

        $display("[TB] two blocks");
        applyStimulus(4'd2, 64, 9, 0, 1'b0);
        waitIdle(1'b0);
        checkMessage(2, 1'b0);

        $display("[TB] saturation");
        applyStimulus(4'd0, 64, 9, 0, 1'b0);
        waitIdle(1'b0);
        checkMessage(0, 1'b0);
        applyStimulus(4'd15, 20, 5, 0, 1'b0);
        waitIdle(1'b0);
        checkMessage(15, 1'b0);
        checkOutput("finalBlk", blk, MAX_BLK - 1);

        $display("[TB] timeout");
        applyStimulus(4'd2, 64, 9, 0, 1'b1);
        waitIdle(1'b0);
        checkMessage(2, 1'b1);
        checkOutput("tmoLatency", errCycle - lastIssueCycle, TMO_CYC);
        checkOutput("tmoCmd", cmdAtErr, 0);
        checkOutput("tmoBusy", busyAtErr, 0);
        repeat (3) tick();
        checkOutput("errSticky", err, 1);
        applyStimulus(4'd1, 30, 4, 0, 1'b0);
        checkOutput("errClearedByStart", err, 0);
        waitIdle(1'b0);
        checkMessage(1, 1'b0);

        $display("[TB] protocol");
        applyStimulus(4'd2, 12, 6, 5, 1'b0);
        waitIdle(1'b1);
        checkMessage(2, 1'b0);

        $display("[TB] reset mid-hash");
        applyStimulus(4'd2, 64, 9, 0, 1'b0);
        for (int c = 0; c < 2000 && cmd != C_HASH; c++) tick();
        checkOutput("reachedHash", cmd, C_HASH);
        rst = 1'b1;
        tick();
        checkOutput("midRstCmd", cmd, 0);
        checkOutput("midRstBlk", blk, 0);
        checkOutput("midRstHInit", hInit, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstErr", err, 0);
        checkOutput("midRstHWe", hWe, 0);
        rst = 1'b0;
        repeat (2) tick();
        applyStimulus(4'd2, 64, 9, 0, 1'b0);
        waitIdle(1'b0);
        checkMessage(2, 1'b0);

        $display("[TB] randomized messages");
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 15);
            applyStimulus(4'(n), $urandom_range(1, 80), $urandom_range(1, 12), $urandom_range(0, 6), 1'b0);
            waitIdle($urandom_range(0, 1) == 1);
            checkMessage(n, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
